// File: rtl/mem_pkg.sv
// Shared sizing and entry layout for the memory issue queue.
// The entry struct is sized from the package constants below.
package mem_pkg;

  localparam int MQ_DEPTH    = 8;
  localparam int MQ_ROB_BITS = 6;
  localparam int MQ_WIDTH    = 16;

  typedef struct packed {
    logic                   valid;
    logic                   is_ld;
    logic [MQ_ROB_BITS-1:0] rob;
    logic [MQ_WIDTH-1:0]    offset;
    logic                   base_rdy;
    logic [MQ_WIDTH-1:0]    base;
    logic                   data_rdy;
    logic [MQ_WIDTH-1:0]    data;
  } mq_entry_t;

  // Effective address; the carry out of the top bit is dropped.
  function automatic logic [MQ_WIDTH-1:0] eff_addr(input logic [MQ_WIDTH-1:0] base,
                                                   input logic [MQ_WIDTH-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/operand_wakeup.sv
// Operand capture from the CDB: a not-ready operand holds its producer tag in its
// low bits and takes the broadcast value when that tag appears.
module operand_wakeup
  import mem_pkg::*;
#(
  parameter int ROB_BITS = MQ_ROB_BITS,
  parameter int WIDTH    = MQ_WIDTH
) (
  input  logic                rdy_in,
  input  logic [WIDTH-1:0]    value_in,
  input  logic                cdb_valid,
  input  logic [ROB_BITS-1:0] cdb_tag,
  input  logic [WIDTH-1:0]    cdb_value,
  output logic                rdy_out,
  output logic [WIDTH-1:0]    value_out
);

  logic hit;

  assign hit       = !rdy_in && cdb_valid && (value_in[ROB_BITS-1:0] == cdb_tag);
  assign rdy_out   = rdy_in | hit;
  assign value_out = hit ? cdb_value : value_in;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: holds dispatched ops until their operands arrive
// on the CDB, then issues one op per cycle from the head to the LSU.
module mem_issue_queue
  import mem_pkg::*;
#(
  parameter int DEPTH    = MQ_DEPTH,
  parameter int ROB_BITS = MQ_ROB_BITS,
  parameter int WIDTH    = MQ_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_ld,
  input  logic [ROB_BITS-1:0] in_rob,
  input  logic [WIDTH-1:0]    in_offset,
  input  logic                in_base_rdy,
  input  logic [WIDTH-1:0]    in_base,
  input  logic                in_data_rdy,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                cdb_valid,
  input  logic [ROB_BITS-1:0] cdb_tag,
  input  logic [WIDTH-1:0]    cdb_value,
  input  logic                load_stall,
  output logic                out_valid,
  output logic                out_is_ld,
  output logic [WIDTH-1:0]    out_data,
  output logic [WIDTH-1:0]    out_location,
  output logic [ROB_BITS-1:0] out_rob
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  mq_entry_t          entries_q [DEPTH];
  mq_entry_t          entries_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic               out_is_ld_q, out_is_ld_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [WIDTH-1:0]   out_location_q, out_location_d;
  logic [ROB_BITS-1:0] out_rob_q, out_rob_d;

  logic               base_rdy_w [DEPTH];
  logic [WIDTH-1:0]   base_w     [DEPTH];
  logic               data_rdy_w [DEPTH];
  logic [WIDTH-1:0]   data_w     [DEPTH];
  logic               byp_base_rdy, byp_data_rdy;
  logic [WIDTH-1:0]   byp_base, byp_data;
  mq_entry_t          head_e;
  logic               dispatch, issue;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    operand_wakeup #(.ROB_BITS(ROB_BITS), .WIDTH(WIDTH)) u_base_wake (
      .rdy_in   (entries_q[g].base_rdy),
      .value_in (entries_q[g].base),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_value(cdb_value),
      .rdy_out  (base_rdy_w[g]),
      .value_out(base_w[g])
    );
    operand_wakeup #(.ROB_BITS(ROB_BITS), .WIDTH(WIDTH)) u_data_wake (
      .rdy_in   (entries_q[g].data_rdy),
      .value_in (entries_q[g].data),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_value(cdb_value),
      .rdy_out  (data_rdy_w[g]),
      .value_out(data_w[g])
    );
  end

  // Same-cycle bypass so an op whose producer broadcasts during dispatch is not lost.
  operand_wakeup #(.ROB_BITS(ROB_BITS), .WIDTH(WIDTH)) u_byp_base (
    .rdy_in   (in_base_rdy),
    .value_in (in_base),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value),
    .rdy_out  (byp_base_rdy),
    .value_out(byp_base)
  );
  operand_wakeup #(.ROB_BITS(ROB_BITS), .WIDTH(WIDTH)) u_byp_data (
    .rdy_in   (in_data_rdy),
    .value_in (in_data),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value),
    .rdy_out  (byp_data_rdy),
    .value_out(byp_data)
  );

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign head_e   = entries_q[head_q];
  assign dispatch = in_valid && in_ready;
  // Eligibility uses registered operand state, so a wakeup only counts next cycle.
  assign issue    = head_e.valid && head_e.base_rdy && (head_e.is_ld || head_e.data_rdy)
                    && !load_stall;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    out_valid_d    = 1'b0;
    out_is_ld_d    = out_is_ld_q;
    out_data_d     = out_data_q;
    out_location_d = out_location_q;
    out_rob_d      = out_rob_q;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i]          = entries_q[i];
      entries_d[i].base_rdy = base_rdy_w[i];
      entries_d[i].base     = base_w[i];
      entries_d[i].data_rdy = data_rdy_w[i];
      entries_d[i].data     = data_w[i];
    end

    if (issue) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + 1'b1;
      out_valid_d             = 1'b1;
      out_is_ld_d             = head_e.is_ld;
      out_rob_d               = head_e.rob;
      out_location_d          = eff_addr(head_e.base, head_e.offset);
      out_data_d              = head_e.is_ld ? '0 : head_e.data;
    end

    // A dispatch never targets the head being popped: it needs count < DEPTH.
    if (dispatch) begin
      entries_d[tail_q].valid    = 1'b1;
      entries_d[tail_q].is_ld    = in_is_ld;
      entries_d[tail_q].rob      = in_rob;
      entries_d[tail_q].offset   = in_offset;
      entries_d[tail_q].base_rdy = byp_base_rdy;
      entries_d[tail_q].base     = byp_base;
      entries_d[tail_q].data_rdy = byp_data_rdy;
      entries_d[tail_q].data     = byp_data;
      tail_d                     = tail_q + 1'b1;
    end

    case ({dispatch, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      out_is_ld_q    <= 1'b0;
      out_data_q     <= '0;
      out_location_q <= '0;
      out_rob_q      <= '0;
      // NOTE: only the valid bits are cleared; payload is don't-care while invalid.
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      out_is_ld_q    <= out_is_ld_d;
      out_data_q     <= out_data_d;
      out_location_q <= out_location_d;
      out_rob_q      <= out_rob_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  assign out_valid    = out_valid_q;
  assign out_is_ld    = out_is_ld_q;
  assign out_data     = out_data_q;
  assign out_location = out_location_q;
  assign out_rob      = out_rob_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-of-ops reference model.
module tb_mem_issue_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_is_ld;
  logic [5:0]  in_rob, cdb_tag, out_rob;
  logic [15:0] in_offset, in_base, in_data, cdb_value, out_data, out_location;
  logic        in_base_rdy, in_data_rdy, cdb_valid, load_stall;
  logic        out_valid, out_is_ld;

  int checks = 0;
  int errors = 0;

  mem_issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_ld(in_is_ld), .in_rob(in_rob),
    .in_offset(in_offset), .in_base_rdy(in_base_rdy), .in_base(in_base),
    .in_data_rdy(in_data_rdy), .in_data(in_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .load_stall(load_stall),
    .out_valid(out_valid), .out_is_ld(out_is_ld), .out_data(out_data),
    .out_location(out_location), .out_rob(out_rob)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        is_ld;
    bit [5:0]  rob;
    bit [15:0] offset;
    bit        base_rdy;
    bit [15:0] base;
    bit        data_rdy;
    bit [15:0] data;
  } op_t;

  op_t       mq[$];
  bit        exp_valid, exp_is_ld;
  bit [15:0] exp_data, exp_loc;
  bit [5:0]  exp_rob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: ops in program order; head issues when its operands are ready,
  // judged on the state before this cycle's broadcast.
  task automatic model_step();
    int n;
    bit acc;
    op_t h, o;
    if (reset || flush) begin
      mq.delete();
      exp_valid = 0; exp_is_ld = 0; exp_data = 0; exp_loc = 0; exp_rob = 0;
      return;
    end
    n = mq.size();
    acc = in_valid && (n != 8);
    exp_valid = 0;
    if (n > 0 && mq[0].base_rdy && (mq[0].is_ld || mq[0].data_rdy) && !load_stall) begin
      h = mq.pop_front();
      exp_valid = 1;
      exp_is_ld = h.is_ld;
      exp_rob   = h.rob;
      exp_loc   = h.base + h.offset;
      exp_data  = h.is_ld ? 16'h0 : h.data;
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].base_rdy && mq[i].base[5:0] == cdb_tag) begin
          mq[i].base = cdb_value; mq[i].base_rdy = 1;
        end
        if (!mq[i].data_rdy && mq[i].data[5:0] == cdb_tag) begin
          mq[i].data = cdb_value; mq[i].data_rdy = 1;
        end
      end
    end
    if (acc) begin
      o.is_ld = in_is_ld; o.rob = in_rob; o.offset = in_offset;
      o.base_rdy = in_base_rdy; o.base = in_base;
      o.data_rdy = in_data_rdy; o.data = in_data;
      if (cdb_valid && !o.base_rdy && o.base[5:0] == cdb_tag) begin
        o.base = cdb_value; o.base_rdy = 1;
      end
      if (cdb_valid && !o.data_rdy && o.data[5:0] == cdb_tag) begin
        o.data = cdb_value; o.data_rdy = 1;
      end
      mq.push_back(o);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_valid);
    check("out_is_ld", out_is_ld, exp_is_ld);
    check("out_data", out_data, exp_data);
    check("out_location", out_location, exp_loc);
    check("out_rob", out_rob, exp_rob);
    check("in_ready", in_ready, mq.size() != 8);
  endtask

  task automatic idle();
    in_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic put(input bit ld, input bit [5:0] rob, input bit [15:0] off,
                     input bit brdy, input bit [15:0] base, input bit drdy,
                     input bit [15:0] data);
    in_valid = 1; in_is_ld = ld; in_rob = rob; in_offset = off;
    in_base_rdy = brdy; in_base = base; in_data_rdy = drdy; in_data = data;
  endtask

  initial begin
    int pulses;
    reset = 1; flush = 0; in_valid = 0; in_is_ld = 0; in_rob = 0; in_offset = 0;
    in_base_rdy = 0; in_base = 0; in_data_rdy = 0; in_data = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; load_stall = 0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_location", out_location, 0);
    reset = 0;

    // Ready load: out_valid two cycles after dispatch.
    put(1, 5, 16'h0004, 1, 16'h1000, 0, 16'h0);
    step(); idle();
    check("t1_valid_n1", out_valid, 0);
    step();
    check("t1_valid_n2", out_valid, 1);
    check("t1_location", out_location, 16'h1004);
    check("t1_is_ld", out_is_ld, 1);
    check("t1_rob", out_rob, 5);
    step();

    // Store waiting on base tag 3.
    put(0, 7, 16'h0010, 0, 16'h0003, 1, 16'hBEEF);
    step(); idle(); step(); step();
    check("t2_waiting", out_valid, 0);
    cdb_valid = 1; cdb_tag = 3; cdb_value = 16'h0200;
    step(); idle();
    check("t2_wake_n1", out_valid, 0);
    step();
    check("t2_valid", out_valid, 1);
    check("t2_location", out_location, 16'h0210);
    check("t2_data", out_data, 16'hBEEF);
    check("t2_is_ld", out_is_ld, 0);
    check("t2_rob", out_rob, 7);
    step();

    // Blocked head keeps a ready younger op waiting.
    put(1, 1, 16'h0000, 0, 16'h0009, 0, 16'h0);
    step();
    put(1, 2, 16'h0000, 1, 16'h0040, 0, 16'h0);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_blocked", out_valid, 0);
    end
    cdb_valid = 1; cdb_tag = 9; cdb_value = 16'h0100;
    step(); idle();
    step();
    check("t3_first_valid", out_valid, 1);
    check("t3_first_rob", out_rob, 1);
    check("t3_first_loc", out_location, 16'h0100);
    step();
    check("t3_second_valid", out_valid, 1);
    check("t3_second_rob", out_rob, 2);
    step();

    // Fill under stall, refuse the ninth, then drain with wrap.
    load_stall = 1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("t4_full_ready", in_ready, 0);
      put(1, 6'(10 + i), 16'h0001, 1, 16'(i * 16), 0, 16'h0);
      step();
    end
    idle();
    check("t4_still_full", in_ready, 0);
    load_stall = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) pulses++;
    end
    check("t4_issue_count", pulses, 8);
    check("t4_ready_after", in_ready, 1);

    // Dispatch bypass from a same-cycle broadcast.
    put(1, 20, 16'h0005, 0, 16'h0002, 0, 16'h0);
    cdb_valid = 1; cdb_tag = 2; cdb_value = 16'h0010;
    step(); idle();
    step();
    check("t5_valid", out_valid, 1);
    check("t5_location", out_location, 16'h0015);
    step();

    // Flush with four queued ops and a simultaneous dispatch.
    load_stall = 1;
    for (int i = 0; i < 4; i++) begin
      put(1, 6'(30 + i), 16'h0000, 1, 16'h0100, 0, 16'h0);
      step();
    end
    put(1, 40, 16'h0000, 1, 16'h0200, 0, 16'h0);
    flush = 1;
    step(); idle();
    check("t6_ready", in_ready, 1);
    check("t6_valid", out_valid, 0);
    check("t6_location", out_location, 0);
    load_stall = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_stale", out_valid, 0);
    end

    // Address wrap.
    put(1, 3, 16'h0002, 1, 16'hFFFF, 0, 16'h0);
    step(); idle();
    step();
    check("t7_valid", out_valid, 1);
    check("t7_wrap_loc", out_location, 16'h0001);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit brdy, drdy;
      brdy = ($urandom_range(0, 1) == 1);
      drdy = ($urandom_range(0, 1) == 1);
      in_valid    = ($urandom_range(0, 99) < 55);
      in_is_ld    = ($urandom_range(0, 1) == 1);
      in_rob      = 6'($urandom);
      in_offset   = 16'($urandom);
      in_base_rdy = brdy;
      in_base     = brdy ? 16'($urandom) : 16'($urandom_range(0, 15));
      in_data_rdy = drdy;
      in_data     = drdy ? 16'($urandom) : 16'($urandom_range(0, 15));
      cdb_valid   = ($urandom_range(0, 1) == 1);
      cdb_tag     = 6'($urandom_range(0, 15));
      cdb_value   = 16'($urandom);
      load_stall  = ($urandom_range(0, 99) < 30);
      flush       = ($urandom_range(0, 99) < 2);
      reset       = ($urandom_range(0, 999) < 3);
      step();
    end
    reset = 0; idle(); load_stall = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
